// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU MEM stage (master) and dmem_responder (slave).
// Signal suffixes follow the responder's original port names.
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        stall_o;

    modport master (
        output req_valid_i, req_write_i, addr_i, wdata_i,
        input  req_ready_o, rsp_valid_o, rdata_o, err_o, stall_o
    );

    modport slave (
        input  req_valid_i, req_write_i, addr_i, wdata_i,
        output req_ready_o, rsp_valid_o, rdata_o, err_o, stall_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory serving one CPU load/store at a time.
// The access completes on the BUSY->RESP edge, LATENCY cycles after acceptance.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_responder_if.slave   bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;

    logic        lat_write_q;
    logic [31:0] lat_addr_q;
    logic [31:0] lat_wdata_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        finish;
    logic [29:0] word_idx;
    logic        bad;
    logic [31:0] rd_word;

    assign accept   = (state_q == IDLE) && bus.req_valid_i;
    assign finish   = (state_q == BUSY) && (count_q == '0);
    assign word_idx = lat_addr_q[31:2];

    // Full 30-bit index compare so high address bits cannot alias into range.
    always_comb begin
        bad     = (lat_addr_q[1:0] != 2'b00) || ({2'b00, word_idx} >= 32'(DEPTH_WORDS));
        rd_word = '0;
        if (!bad) begin
            rd_word = mem[word_idx[AW-1:0]];
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    state_d = BUSY;
                    count_d = LAT_M1;
                end
            end
            BUSY: begin
                if (count_q == '0) begin
                    state_d = RESP;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else if (accept) begin
            lat_write_q <= bus.req_write_i;
            lat_addr_q  <= bus.addr_i;
            lat_wdata_q <= bus.wdata_i;
        end
    end

    // rdata holds across IDLE; err is only meaningful alongside the response strobe.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (finish) begin
            rdata_q <= lat_write_q ? '0 : rd_word;
            err_q   <= bad;
        end else if (state_q == RESP) begin
            err_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (finish && lat_write_q && !bad) begin
            mem[word_idx[AW-1:0]] <= lat_wdata_q;
        end
    end

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rdata_o     = rdata_q;
    assign bus.err_o       = err_q;
    assign bus.stall_o     = (state_q == BUSY) || accept;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector bench: drivers push expected responses, negedge monitors pop and compare.
module tb_dmem_responder;
    logic clk;
    logic rst_n;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t q0[$];
    rsp_t q1[$];

    dmem_responder_if bus0();
    dmem_responder_if bus1();

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) dut0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus0.slave)
    );

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input bit fast, input logic v, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        if (fast) begin
            bus1.req_valid_i = v; bus1.req_write_i = w; bus1.addr_i = a; bus1.wdata_i = d;
        end else begin
            bus0.req_valid_i = v; bus0.req_write_i = w; bus0.addr_i = a; bus0.wdata_i = d;
        end
    endtask

    function automatic logic get_ready(input bit fast);
        return fast ? bus1.req_ready_o : bus0.req_ready_o;
    endfunction
    function automatic logic get_rsp(input bit fast);
        return fast ? bus1.rsp_valid_o : bus0.rsp_valid_o;
    endfunction
    function automatic logic get_stall(input bit fast);
        return fast ? bus1.stall_o : bus0.stall_o;
    endfunction

    always @(negedge clk) begin
        if (bus0.rsp_valid_o === 1'b1) begin
            if (q0.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_rsp0: got rsp_valid 1 expected 0 at %0t", $time);
            end else begin
                rsp_t e;
                e = q0.pop_front();
                chk("rdata0", bus0.rdata_o, e.rdata);
                chk("err0", 32'(bus0.err_o), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.rsp_valid_o === 1'b1) begin
            if (q1.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_rsp1: got rsp_valid 1 expected 0 at %0t", $time);
            end else begin
                rsp_t e;
                e = q1.pop_front();
                chk("rdata1", bus1.rdata_o, e.rdata);
                chk("err1", 32'(bus1.err_o), 32'(e.err));
            end
        end
    end

    // One full access with cycle-exact handshake checks; mutate scrambles inputs during BUSY.
    task automatic access(input bit fast, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rdata,
                          input logic exp_err, input bit mutate);
        int lat;
        rsp_t e;
        lat = fast ? 1 : 2;
        @(negedge clk);
        chk("ready_idle", 32'(get_ready(fast)), 32'd1);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        if (fast) q1.push_back(e); else q0.push_back(e);
        set_req(fast, 1'b1, wr, a, d);
        #1;
        chk("stall_req", 32'(get_stall(fast)), 32'd1);
        @(posedge clk);
        #1;
        chk("ready_busy", 32'(get_ready(fast)), 32'd0);
        chk("stall_busy", 32'(get_stall(fast)), 32'd1);
        if (mutate) set_req(fast, 1'b1, ~wr, a + 32'd4, d + 32'd1);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            chk("rsp_timing", 32'(get_rsp(fast)), (k == lat) ? 32'd1 : 32'd0);
            chk("stall_timing", 32'(get_stall(fast)), (k == lat) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        set_req(fast, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        chk("rsp_one_cycle", 32'(get_rsp(fast)), 32'd0);
        chk("ready_after_resp", 32'(get_ready(fast)), 32'd1);
    endtask

    initial begin
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(bus0.req_ready_o), 32'd1);
        chk("rst_rsp", 32'(bus0.rsp_valid_o), 32'd0);
        chk("rst_rdata", bus0.rdata_o, 32'd0);
        chk("rst_err", 32'(bus0.err_o), 32'd0);
        chk("rst_stall", 32'(bus0.stall_o), 32'd0);
        access(1'b0, 1'b0, 32'h0000_0000, '0, 32'h0, 1'b0, 1'b0);

        access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0010, '0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        access(1'b0, 1'b1, 32'h0000_0013, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0010, '0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        access(1'b0, 1'b0, 32'h0000_0200, '0, 32'h0, 1'b1, 1'b0);
        access(1'b0, 1'b1, 32'h0000_01FC, 32'h0000_A5A5, 32'h0, 1'b0, 1'b0);
        access(1'b0, 1'b0, 32'h0000_01FC, '0, 32'h0000_A5A5, 1'b0, 1'b0);
        access(1'b0, 1'b0, 32'h8000_0010, '0, 32'h0, 1'b1, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0012, '0, 32'h0, 1'b1, 1'b0);

        access(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0001, 32'h0, 1'b0, 1'b1);
        access(1'b0, 1'b0, 32'h0000_0020, '0, 32'h0000_0001, 1'b0, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0024, '0, 32'h0, 1'b0, 1'b0);

        access(1'b1, 1'b1, 32'h0000_0010, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0010, '0, 32'h0BAD_F00D, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0011, '0, 32'h0, 1'b1, 1'b0);

        // Reset during BUSY: no response may appear (monitor flags any strobe).
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 32'h0000_0028, 32'h0000_CAFE);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("midrst_ready", 32'(bus0.req_ready_o), 32'd1);
        chk("midrst_rsp", 32'(bus0.rsp_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        access(1'b0, 1'b0, 32'h0000_0028, '0, 32'h0, 1'b0, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0010, '0, 32'h0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
